// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode groups, per-group op codes,
// flag bit positions and the controller state encoding.
package alu_pkg;

    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_SHIFT = 2'b10;
    localparam logic [1:0] GRP_MUL   = 2'b11;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADC  = 2'b10;
    localparam logic [1:0] OP_SBB  = 2'b11;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NOT  = 2'b11;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROL  = 2'b11;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;

    // Flags are packed {Z,N,C,V}, so Z is the most significant bit.
    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Only MUL and MULH use the iterative multiplier; the two reserved codes
    // of the multiply group complete in a single cycle.
    function automatic logic isIterMul(input logic [3:0] opcode);
        return (opcode[3:2] == GRP_MUL) && (opcode[1] == 1'b0);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per clock,
// DATA_WIDTH iterations after start, full 2*DATA_WIDTH product held afterwards.
module alu_mul_iter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [DATA_WIDTH-1:0]     a_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [2*DATA_WIDTH-1:0]   product_o
);

    localparam int W   = DATA_WIDTH;
    localparam int CNW = $clog2(DATA_WIDTH);
    localparam logic [CNW-1:0] LAST = CNW'(W - 1);

    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] product_q;
    logic [CNW-1:0] count_q;
    logic           busy_q;

    // done_o marks the cycle whose closing edge performs the final iteration.
    assign done_o    = busy_q && (count_q == LAST);
    assign busy_o    = busy_q;
    assign product_o = product_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
        end else if (start_i) begin
            mcand_q   <= {{W{1'b0}}, a_i};
            mplier_q  <= b_i;
            product_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                product_q <= product_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered, valid/ready handshaked ALU with Z/N/C/V flags, a chaining carry
// register for ADC/SBB and an iterative unsigned multiply group.
module alu_pipe
    import alu_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    parameter  int OPCODE_WIDTH = 4,
    localparam int SHW          = $clog2(DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   result,
    output logic [3:0]              flags,
    output logic                    carry_q
);

    localparam int W   = DATA_WIDTH;
    localparam int MSB = DATA_WIDTH - 1;

    state_t         state_q;
    logic           outValid_q;
    logic [W-1:0]   result_q;
    logic [3:0]     flags_q;
    logic           mulHigh_q;

    logic           inXfer;
    logic           outXfer;
    logic [1:0]     grp;
    logic [1:0]     op;
    logic [SHW-1:0] shamt;

    logic [W-1:0]   aluResult_d;
    logic           aluC_d;
    logic           aluV_d;
    logic [3:0]     aluFlags_d;
    logic [W-1:0]   mulResult_d;
    logic [3:0]     mulFlags_d;

    logic [W:0]     arith;
    logic           carryIn;
    logic [2*W-1:0] sllExt;
    logic [2*W-1:0] rolExt;
    logic [W:0]     srlExt;
    logic [W:0]     sraExt;

    logic           mulStart;
    logic           mulBusy;
    logic           mulDone;
    logic [2*W-1:0] mulProduct;

    assign grp   = opcode[3:2];
    assign op    = opcode[1:0];
    assign shamt = b[SHW-1:0];

    assign in_ready  = (state_q == IDLE) && (!outValid_q || out_ready);
    assign inXfer    = in_valid && in_ready;
    assign outXfer   = outValid_q && out_ready;
    assign out_valid = outValid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    assign mulStart = inXfer && isIterMul(opcode);

    alu_mul_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mulStart),
        .a_i       (a),
        .b_i       (b),
        .busy_o    (mulBusy),
        .done_o    (mulDone),
        .product_o (mulProduct)
    );

    // Shifters work on widened copies so the last bit shifted out lands in a
    // fixed position (and is naturally zero for a shift of 0).
    always_comb begin
        carryIn = (op == OP_ADC || op == OP_SBB) ? carry_q : 1'b0;
        if (op[0]) begin
            arith = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, carryIn};
        end else begin
            arith = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carryIn};
        end
        sllExt = {{W{1'b0}}, a} << shamt;
        rolExt = {a, a} << shamt;
        srlExt = {a, 1'b0} >> shamt;
        sraExt = $signed({a, 1'b0}) >>> shamt;
    end

    always_comb begin
        aluResult_d = '0;
        aluC_d      = 1'b0;
        aluV_d      = 1'b0;
        case (grp)
            GRP_ARITH: begin
                aluResult_d = arith[W-1:0];
                aluC_d      = arith[W];
                if (op[0]) begin
                    aluV_d = (a[MSB] != b[MSB]) && (arith[MSB] != a[MSB]);
                end else begin
                    aluV_d = (a[MSB] == b[MSB]) && (arith[MSB] != a[MSB]);
                end
            end
            GRP_LOGIC: begin
                case (op)
                    OP_AND:  aluResult_d = a & b;
                    OP_OR:   aluResult_d = a | b;
                    OP_XOR:  aluResult_d = a ^ b;
                    default: aluResult_d = ~a;
                endcase
            end
            GRP_SHIFT: begin
                case (op)
                    OP_SLL: begin
                        aluResult_d = sllExt[W-1:0];
                        aluC_d      = sllExt[W];
                    end
                    OP_SRL: begin
                        aluResult_d = srlExt[W:1];
                        aluC_d      = srlExt[0];
                    end
                    OP_SRA: begin
                        aluResult_d = sraExt[W:1];
                        aluC_d      = sraExt[0];
                    end
                    default: aluResult_d = rolExt[2*W-1:W];
                endcase
            end
            default: aluResult_d = '0;
        endcase

        aluFlags_d        = '0;
        aluFlags_d[FLG_Z] = (aluResult_d == '0);
        aluFlags_d[FLG_N] = aluResult_d[MSB];
        aluFlags_d[FLG_C] = aluC_d;
        aluFlags_d[FLG_V] = aluV_d;
    end

    always_comb begin
        mulResult_d       = mulHigh_q ? mulProduct[2*W-1:W] : mulProduct[W-1:0];
        mulFlags_d        = '0;
        mulFlags_d[FLG_Z] = (mulResult_d == '0);
        mulFlags_d[FLG_N] = mulResult_d[MSB];
        mulFlags_d[FLG_C] = !mulHigh_q && (mulProduct[2*W-1:W] != '0);
        mulFlags_d[FLG_V] = 1'b0;
    end

    // Accepting a new op implies the output register is empty or being
    // drained this cycle, so the MUL path can safely clear out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
            carry_q    <= 1'b0;
            mulHigh_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inXfer) begin
                        if (isIterMul(opcode)) begin
                            state_q    <= MUL;
                            mulHigh_q  <= (op == OP_MULH);
                            outValid_q <= 1'b0;
                        end else begin
                            result_q   <= aluResult_d;
                            flags_q    <= aluFlags_d;
                            outValid_q <= 1'b1;
                            if (grp == GRP_ARITH) begin
                                carry_q <= aluFlags_d[FLG_C];
                            end
                        end
                    end else if (outXfer) begin
                        outValid_q <= 1'b0;
                    end
                end
                MUL: begin
                    // A non-busy multiplier here can only mean it was lost; never stall.
                    if (mulDone || !mulBusy) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    result_q   <= mulResult_d;
                    flags_q    <= mulFlags_d;
                    outValid_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
